// File: rtl/actuador_puertas.sv
// -----------------------------------------------------------------------------
// actuador_puertas
//
// Door mechanism model for the elevator car. It receives the door command and
// the obstruction sensor, moves a position counter between fully closed (0)
// and fully open (T_MOV), and counts the open dwell time. When the door has
// been fully open for T_ESPERA cycles without a restart, it raises a timeout.
//
// Parameters:
//   T_MOV     cycles for a full travel in either direction (>= 2)
//   T_ESPERA  cycles fully open, with no restart, before timeout (>= 1)
//   MAX_REV   sensor reversals before falla is raised (PUERTAS_FALLA_EN only)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   orden    in   [1:0] command: 01 open, 10 close, 00/11 nothing
//   sensor   in   obstruction between the doors (1 = sensed)
//   puertas  out  [1:0] registered status: 00 closed, 01 open,
//                 10 closing, 11 opening
//   timeout  out  registered open-hold timeout
//   falla    out  sticky reversal fault (PUERTAS_FALLA_EN only)
//
// Optional feature macro: PUERTAS_FALLA_EN
//   Defined:   adds MAX_REV, the falla output and a reversal counter.
//   Undefined: no falla port; door behaviour is otherwise identical.
//
// States:
//   state    | meaning
//   CERRADA  | fully closed, pos = 0
//   ABIERTA  | fully open, pos = T_MOV, hold counter running
//   CERRANDO | closing, pos decrements every edge
//   ABRIENDO | opening, pos increments every edge
// -----------------------------------------------------------------------------
module actuador_puertas #(
    parameter int T_MOV    = 8,
    parameter int T_ESPERA = 16
`ifdef PUERTAS_FALLA_EN
    ,
    parameter int MAX_REV  = 3
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] orden,
    input  logic       sensor,
    output logic [1:0] puertas,
    output logic       timeout
`ifdef PUERTAS_FALLA_EN
    ,
    output logic       falla
`endif
);

    localparam int POS_W  = $clog2(T_MOV + 1);
    localparam int HOLD_W = $clog2(T_ESPERA + 1);

    localparam logic [POS_W-1:0]  POS_ZERO = '0;
    localparam logic [POS_W-1:0]  POS_ONE  = POS_W'(1);
    localparam logic [POS_W-1:0]  POS_LAST = POS_W'(T_MOV - 1);
    localparam logic [POS_W-1:0]  POS_MAX  = POS_W'(T_MOV);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(T_ESPERA);

    typedef enum logic [1:0] {
        CERRADA  = 2'b00,
        ABIERTA  = 2'b01,
        CERRANDO = 2'b10,
        ABRIENDO = 2'b11
    } estado_t;

    estado_t           estado, estado_next;
    logic [POS_W-1:0]  pos, pos_next;
    logic [HOLD_W-1:0] hold, hold_next;
    logic              timeout_next;

    // Sensor outranks every command; a close request only counts when the
    // doorway is clear. orden == 11 falls through as "nothing".
    logic abrir;
    logic cerrar;

    assign abrir  = sensor | (orden == 2'b01);
    assign cerrar = ~sensor & (orden == 2'b10);

`ifdef PUERTAS_FALLA_EN
    localparam int REV_W = $clog2(MAX_REV + 1);
    localparam logic [REV_W-1:0] REV_ONE = REV_W'(1);
    localparam logic [REV_W-1:0] REV_MAX = REV_W'(MAX_REV);

    logic [REV_W-1:0] rev, rev_next;
    logic             falla_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado  <= CERRADA;
            pos     <= '0;
            hold    <= '0;
            timeout <= 1'b0;
`ifdef PUERTAS_FALLA_EN
            rev     <= '0;
            falla   <= 1'b0;
`endif
        end else begin
            estado  <= estado_next;
            pos     <= pos_next;
            hold    <= hold_next;
            timeout <= timeout_next;
`ifdef PUERTAS_FALLA_EN
            rev     <= rev_next;
            falla   <= falla_next;
`endif
        end
    end

    always_comb begin
        estado_next  = estado;
        pos_next     = pos;
        hold_next    = hold;
        timeout_next = 1'b0;
`ifdef PUERTAS_FALLA_EN
        rev_next     = rev;
`endif

        case (estado)
            CERRADA: begin
                pos_next = POS_ZERO;
                if (abrir) begin
                    estado_next = ABRIENDO;
                end
            end

            ABRIENDO: begin
                // A reversal holds pos on the reversal edge, even when this
                // edge would otherwise have completed the travel. The >=
                // also covers a reopen from pos == T_MOV (closing aborted on
                // its very first edge).
                if (cerrar) begin
                    estado_next = CERRANDO;
                end else if (pos >= POS_LAST) begin
                    pos_next    = POS_MAX;
                    hold_next   = '0;
                    estado_next = ABIERTA;
                end else begin
                    pos_next = pos + POS_ONE;
                end
            end

            ABIERTA: begin
                if (abrir) begin
                    hold_next = '0;
                end else if (cerrar) begin
                    hold_next   = '0;
                    estado_next = CERRANDO;
                end else begin
                    if (hold != HOLD_MAX) begin
                        hold_next = hold + HOLD_ONE;
                    end
                    timeout_next = (hold_next == HOLD_MAX);
                end
            end

            CERRANDO: begin
                if (abrir) begin
                    estado_next = ABRIENDO;
`ifdef PUERTAS_FALLA_EN
                    if (sensor && (rev != REV_MAX)) begin
                        rev_next = rev + REV_ONE;
                    end
`endif
                end else if (pos <= POS_ONE) begin
                    // <= also catches a close that began at pos 0 (opening
                    // reversed on its first edge).
                    pos_next    = POS_ZERO;
                    estado_next = CERRADA;
`ifdef PUERTAS_FALLA_EN
                    rev_next    = '0;
`endif
                end else begin
                    pos_next = pos - POS_ONE;
                end
            end

            default: begin
                estado_next = CERRADA;
                pos_next    = POS_ZERO;
                hold_next   = '0;
            end
        endcase

`ifdef PUERTAS_FALLA_EN
        falla_next = falla | (rev_next == REV_MAX);
`endif
    end

    assign puertas = estado;

endmodule
